// File: rtl/nbit_sync_qual.sv
// Stability qualifier for a synchronized multi-bit bus: a value is accepted only after
// it holds for STABLE cycles, then offered on valid/ready with a change mask and overflow flag.
module nbit_sync_qual #(
    parameter int unsigned         WIDTH   = 1,
    parameter int unsigned         STABLE  = 4,
    parameter logic [WIDTH-1:0]    RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             sync_out_clk,
    input  logic             sync_out_rst,
    input  logic [WIDTH-1:0] qual_in,
    input  logic             qual_ready,
    output logic             qual_valid,
    output logic [WIDTH-1:0] qual_data,
    output logic [WIDTH-1:0] qual_chg_mask,
    output logic             qual_stable,
    output logic             qual_ovfl
);

    localparam int unsigned       CNT_W    = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0]  CNT_QUAL = CNT_W'(STABLE - 1);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dlv_q, dlv_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;
    logic             ovfl_q, ovfl_d;
    logic             stable_q, stable_d;

    logic same_c;
    logic evt_c;
    logic new_word_c;
    logic hs_c;

    // Stable-run counter and qualify event (fires once, on the saturating step).
    always_comb begin
        prev_d = qual_in;
        same_c = (qual_in == prev_q);
        cnt_d  = cnt_q;
        if (!same_c) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end
        evt_c      = same_c && (cnt_q == CNT_QUAL);
        new_word_c = evt_c && (prev_q != acc_q);
        stable_d   = (cnt_d == CNT_MAX);
    end

    // Output word, change mask and overflow bookkeeping.
    always_comb begin
        hs_c    = valid_q & qual_ready;
        acc_d   = acc_q;
        dlv_d   = dlv_q;
        data_d  = data_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        ovfl_d  = ovfl_q;

        if (hs_c) begin
            dlv_d   = data_q;
            valid_d = 1'b0;
        end

        if (new_word_c) begin
            acc_d   = prev_q;
            data_d  = prev_q;
            valid_d = 1'b1;
            if (!valid_q || hs_c) begin
                mask_d = prev_q ^ (hs_c ? data_q : dlv_q);
            end else begin
                // Pending word overwritten: newest data wins, mask keeps every changed bit.
                mask_d = mask_q | (prev_q ^ acc_q);
                ovfl_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sync_out_clk) begin
        if (sync_out_rst) begin
            prev_q   <= RST_VAL;
            cnt_q    <= '0;
            acc_q    <= RST_VAL;
            dlv_q    <= RST_VAL;
            data_q   <= RST_VAL;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            ovfl_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dlv_q    <= dlv_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            ovfl_q   <= ovfl_d;
            stable_q <= stable_d;
        end
    end

    assign qual_valid    = valid_q;
    assign qual_data     = data_q;
    assign qual_chg_mask = mask_q;
    assign qual_stable   = stable_q;
    assign qual_ovfl     = ovfl_q;

endmodule

// File: tb/tb_nbit_sync_qual.sv
// Directed bench for nbit_sync_qual (WIDTH=4, STABLE=4, RST_VAL=0) with hand-computed expectations.
module tb_nbit_sync_qual;

    logic       clk;
    logic       rst;
    logic [3:0] qin;
    logic       rdy;
    logic       valid;
    logic [3:0] data;
    logic [3:0] mask;
    logic       stable;
    logic       ovfl;

    int n_vec;
    int n_err;

    nbit_sync_qual #(
        .WIDTH  (4),
        .STABLE (4),
        .RST_VAL(4'h0)
    ) dut (
        .sync_out_clk (clk),
        .sync_out_rst (rst),
        .qual_in      (qin),
        .qual_ready   (rdy),
        .qual_valid   (valid),
        .qual_data    (data),
        .qual_chg_mask(mask),
        .qual_stable  (stable),
        .qual_ovfl    (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 32'(valid), 32'd0);
        end
    endtask

    task automatic chk_word(input string tag, input logic [3:0] d, input logic [3:0] m);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_data"},  32'(data),  32'(d));
        chk({tag, "_mask"},  32'(mask),  32'(m));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"},  32'(valid),  32'd0);
        chk({tag, "_data"},   32'(data),   32'd0);
        chk({tag, "_mask"},   32'(mask),   32'd0);
        chk({tag, "_stable"}, 32'(stable), 32'd0);
        chk({tag, "_ovfl"},   32'(ovfl),   32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        qin = 4'h0;
        rdy = 1'b0;
        #2;

        // Reset state, then stable rises after four quiet edges.
        tick();
        tick();
        chk_reset_outs("rst");
        rst = 1'b0;
        idle("rst_idle", 3);
        chk("rst_stable_3", 32'(stable), 32'd0);
        tick();
        chk("rst_stable_4", 32'(stable), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ovfl", 32'(ovfl), 32'd0);

        // Glitch 0->1 for two cycles then back: no word.
        rdy = 1'b1;
        qin = 4'h1;
        tick();
        chk("glitch_stable_drop", 32'(stable), 32'd0);
        chk("glitch_valid0", 32'(valid), 32'd0);
        tick();
        qin = 4'h0;
        idle("glitch_idle", 10);
        chk("glitch_stable_back", 32'(stable), 32'd1);

        // Skewed bits: 3 then F two cycles later -> single word F.
        qin = 4'h3;
        idle("skew_idle3", 2);
        qin = 4'hF;
        idle("skew_idleF", 4);
        tick();
        chk_word("skew", 4'hF, 4'hF);
        chk("skew_stable", 32'(stable), 32'd1);
        tick();
        chk("skew_pulse", 32'(valid), 32'd0);

        // Clean change F->A with ready high: one-cycle pulse, mask A^F.
        qin = 4'hA;
        idle("clean_idle", 4);
        tick();
        chk_word("clean", 4'hA, 4'h5);
        tick();
        chk("clean_pulse", 32'(valid), 32'd0);
        chk("clean_ovfl", 32'(ovfl), 32'd0);

        // Overflow: ready low, words 1 then 3.
        qin = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b0;
        qin = 4'h1;
        idle("ovf_idle1", 4);
        tick();
        chk_word("ovf_w1", 4'h1, 4'h1);
        chk("ovf_w1_flag", 32'(ovfl), 32'd0);
        qin = 4'h3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_hold_data", 32'(data), 32'h1);
        end
        tick();
        chk_word("ovf_w3", 4'h3, 4'h3);
        chk("ovf_flag", 32'(ovfl), 32'd1);
        rdy = 1'b1;
        tick();
        chk("ovf_hs_drop", 32'(valid), 32'd0);
        chk("ovf_sticky", 32'(ovfl), 32'd1);
        qin = 4'h2;
        idle("ovf_idle2", 4);
        tick();
        chk_word("ovf_w2", 4'h2, 4'h1);
        tick();
        chk("ovf_w2_pulse", 32'(valid), 32'd0);

        // Handshake in the same cycle as a new word: loads without overflow.
        qin = 4'h0;
        rst = 1'b1;
        tick();
        chk("b2b_rst_ovfl", 32'(ovfl), 32'd0);
        rst = 1'b0;
        rdy = 1'b0;
        qin = 4'h5;
        idle("b2b_idle", 4);
        tick();
        chk_word("b2b_w5", 4'h5, 4'h5);
        qin = 4'h6;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_hold", 32'(data), 32'h5);
        end
        rdy = 1'b1;
        tick();
        chk_word("b2b_w6", 4'h6, 4'h3);
        chk("b2b_no_ovfl", 32'(ovfl), 32'd0);
        tick();
        chk("b2b_drop", 32'(valid), 32'd0);

        // Reset at cnt=2 discards the count; bus 9 then qualifies as a change.
        qin = 4'h9;
        idle("mid_idle", 3);
        rst = 1'b1;
        tick();
        chk_reset_outs("mid_rst");
        rst = 1'b0;
        idle("mid_post", 4);
        tick();
        chk_word("mid_w9", 4'h9, 4'h9);
        tick();
        chk("mid_drop", 32'(valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
